alu_uart_sequencer: RTL
=======================

# alu_uart_sequencer

Byte-serial front end that drives the `alu` block from a UART receiver and returns the result to a UART transmitter. The block collects three received bytes in order: operand A, operand B, then opcode. It presents them to the ALU, strobes the ALU's valid input for one cycle, and captures the registered result. It then hands the result byte to the transmitter and waits for transmit completion before accepting a new frame.

## Interface
- `NB_DATA`, 8, operand/result width; equals UART byte width.
- `NB_OPERATION`, 6, opcode width; must be ≤ `NB_DATA`.
- `NB_TIMEOUT`, 24, width of the inter-byte timeout counter.
- `TIMEOUT_CYCLES`, 24'd10_000_000, idle cycles allowed between bytes of one frame.

Ports:
- `i_clock`  in  1  clock; all logic on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  NB_DATA  received byte; valid only while `i_rx_done` is high.
- `i_rx_done`  in  1  one-cycle strobe, byte received.
- `i_tx_done`  in  1  one-cycle strobe, transmitter finished the byte.
- `i_alu_result`  in  NB_DATA  ALU registered output.
- `o_data_a`  out  NB_DATA  operand A to ALU.
- `o_data_b`  out  NB_DATA  operand B to ALU.
- `o_operation`  out  NB_OPERATION  opcode to ALU.
- `o_alu_valid`  out  1  one-cycle enable to ALU `i_valid`.
- `o_tx_data`  out  NB_DATA  byte to transmit.
- `o_tx_start`  out  1  one-cycle start strobe to transmitter.
- `o_busy`  out  1  high in every state except `WAIT_A`.
- `o_timeout`  out  1  sticky; set on a frame timeout, cleared when the next frame's A byte is accepted.

## Operation
- FSM states are `WAIT_A`, `WAIT_B`, `WAIT_OP`, `EXEC`, `CAPTURE`, `SEND`, `WAIT_TX`.
- **`WAIT_A`:** on `i_rx_done`, register `o_data_a` ← `i_rx_data`, clear `o_timeout`, go to `WAIT_B`.
- **`WAIT_B`:** on `i_rx_done`, register `o_data_b`, go to `WAIT_OP`.
- **`WAIT_OP`:** on `i_rx_done`, register `o_operation` ← `i_rx_data[NB_OPERATION-1:0]`; upper bits are discarded. Go to `EXEC`.
- **`EXEC`:** `o_alu_valid`=1 for exactly this cycle; go to `CAPTURE`.
- **`CAPTURE`:** register `o_tx_data` ← `i_alu_result`; go to `SEND`.
- **`SEND`:** `o_tx_start`=1 for exactly this cycle; go to `WAIT_TX`.
- **`WAIT_TX`:** on `i_tx_done`, go to `WAIT_A`.
- **Timeout counter:**
  - Cleared on every state change and on every accepted byte.
  - Increments each cycle in `WAIT_B` and `WAIT_OP`.
  - On reaching `TIMEOUT_CYCLES-1`, go to `WAIT_A` and set `o_timeout`. Operand registers keep their old values.
  - There is no timeout in `WAIT_A` or `WAIT_TX`.
- **Ignored strobes:**
  - `i_rx_done` in `EXEC`, `CAPTURE`, `SEND` or `WAIT_TX` is dropped; it does not start a new frame.
  - `i_tx_done` outside `WAIT_TX` is ignored.
- **Timeout collision:** if `i_rx_done` and the timeout terminal count occur in the same cycle, the byte wins. It is accepted and the counter clears.
- **Output hold:** `o_data_a`, `o_data_b` and `o_operation` hold between frames; the ALU inputs remain stable.

## Timing
- **Reset values:** state `WAIT_A`; every output 0; `o_busy`=0; `o_timeout`=0; timeout counter 0.
- **Reset mid-frame:** reset in any state aborts the frame on the next edge. No `o_alu_valid` or `o_tx_start` is issued afterwards.
- **Latency**, with the opcode's `i_rx_done` in cycle t:
  - `o_alu_valid` high in cycle t+1.
  - The ALU registers the result at the end of t+1.
  - `o_tx_data` is captured at the end of t+2 and is valid from t+3.
  - `o_tx_start` is high in cycle t+3.
- **Data stability:** `o_tx_data` is stable from t+3 until the next `CAPTURE`.
- **`o_busy` timing:** rises the cycle after the A byte is accepted. It falls the cycle after `i_tx_done` is seen in `WAIT_TX`.
- **Minimum frame turnaround:** the A byte of the next frame may arrive in the cycle after `WAIT_A` is re-entered.
- **Strobe widths:** all strobes are single-cycle; back-to-back `i_rx_done` on consecutive cycles is legal and each strobe advances one state.

## Test plan
- **ADD:** rx bytes 0x05, 0x03, 0x20 with ALU model → `o_alu_valid` one pulse at t+1; `o_tx_data`=0x08 and `o_tx_start` pulse at t+3; `i_tx_done` → `o_busy`=0, state `WAIT_A`.
- **SUB wrap and opcode truncation:**
  - rx 0x02, 0x05, 0xE2 → `o_operation`=0x22.
  - Result 0xFD transmitted.
- **Timeout:**
  - rx 0x11, then no byte for `TIMEOUT_CYCLES` → back in `WAIT_A`, `o_timeout`=1, no `o_alu_valid`.
  - Next rx 0x07 clears `o_timeout`.
- **Dropped bytes:** `i_rx_done` with 0x55 during `WAIT_TX` → ignored; the following frame 0x01, 0x01, 0x24 yields 0x01.
- **Reset mid-frame:** assert `i_reset` in `WAIT_OP` → all outputs 0 next cycle; a subsequent full frame works normally.
- **Back-to-back strobes:** `i_rx_done` on three consecutive cycles with 0x0F, 0xF0, 0x25 → `o_alu_valid` in the 4th cycle; transmitted result 0xFF.

Source files
------------

// File: rtl/alu_uart_sequencer.sv
// Byte-serial front end for the ALU: collects A, B and opcode from a UART receiver,
// strobes the ALU, captures its result and hands it to the UART transmitter.
module alu_uart_sequencer #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OPERATION   = 6,
  parameter int unsigned NB_TIMEOUT     = 24,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_DATA-1:0]      i_rx_data,
  input  logic                    i_rx_done,
  input  logic                    i_tx_done,
  input  logic [NB_DATA-1:0]      i_alu_result,
  output logic [NB_DATA-1:0]      o_data_a,
  output logic [NB_DATA-1:0]      o_data_b,
  output logic [NB_OPERATION-1:0] o_operation,
  output logic                    o_alu_valid,
  output logic [NB_DATA-1:0]      o_tx_data,
  output logic                    o_tx_start,
  output logic                    o_busy,
  output logic                    o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, CAPTURE, SEND, WAIT_TX
  } state_e;

  localparam logic [NB_TIMEOUT-1:0] TIMER_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [NB_TIMEOUT-1:0]   timer_q, timer_d;
  logic [NB_DATA-1:0]      data_a_q, data_a_d;
  logic [NB_DATA-1:0]      data_b_q, data_b_d;
  logic [NB_OPERATION-1:0] operation_q, operation_d;
  logic [NB_DATA-1:0]      tx_data_q, tx_data_d;
  logic                    timeout_q, timeout_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= WAIT_A;
      timer_q     <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      operation_q <= '0;
      tx_data_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      operation_q <= operation_d;
      tx_data_q   <= tx_data_d;
      timeout_q   <= timeout_d;
    end
  end

  // The timer only survives a cycle by explicitly counting; any other path clears it.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    operation_d = operation_q;
    tx_data_d   = tx_data_q;
    timeout_d   = timeout_q;
    case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          data_a_d  = i_rx_data;
          timeout_d = 1'b0;
          state_d   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          data_b_d = i_rx_data;
          state_d  = WAIT_OP;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end else begin
          timer_d = timer_q + NB_TIMEOUT'(1);
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          operation_d = i_rx_data[NB_OPERATION-1:0];
          state_d     = EXEC;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end else begin
          timer_d = timer_q + NB_TIMEOUT'(1);
        end
      end
      EXEC:    state_d = CAPTURE;
      CAPTURE: begin
        tx_data_d = i_alu_result;
        state_d   = SEND;
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign o_data_a    = data_a_q;
  assign o_data_b    = data_b_q;
  assign o_operation = operation_q;
  assign o_tx_data   = tx_data_q;
  assign o_timeout   = timeout_q;
  assign o_alu_valid = (state_q == EXEC);
  assign o_tx_start  = (state_q == SEND);
  assign o_busy      = (state_q != WAIT_A);

endmodule
